// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: op codes, arbiter FSM encodings and op legality helper.
// Imported by the ALU datapath and the two-requester arbiter.
package alu_arbiter_pkg;

  localparam int ALU_WIDTH = 32;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t OP_AND = 3'b000;
  localparam alu_op_t OP_OR  = 3'b001;
  localparam alu_op_t OP_ADD = 3'b010;
  localparam alu_op_t OP_SUB = 3'b110;
  localparam alu_op_t OP_SLT = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic op_is_legal(input alu_op_t op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_arbiter_yalu.sv
// Combinational ALU: AND/OR/ADD/SUB/SLT; illegal op codes give zero and raise o_err.
module yAlu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  alu_op_t          i_op,
  output logic [WIDTH-1:0] o_z,
  output logic             o_err
);

  logic w_slt;
  assign w_slt = $signed(i_a) < $signed(i_b);

  always_comb begin
    o_z   = '0;
    o_err = !op_is_legal(i_op);
    case (i_op)
      OP_AND:  o_z = i_a & i_b;
      OP_OR:   o_z = i_a | i_b;
      OP_ADD:  o_z = i_a + i_b;
      OP_SUB:  o_z = i_a - i_b;
      OP_SLT:  o_z = {{(WIDTH-1){1'b0}}, w_slt};
      default: o_z = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU; one operation in flight,
// result held in RESP until the consumer accepts it.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_id,
  output logic             rsp_err
);

  logic [1:0]       r_state;
  logic             r_ptr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  alu_op_t          r_op;
  logic             r_id;
  logic [WIDTH-1:0] r_z;
  logic             r_err;

  logic             w_idle;
  logic             w_gnt;
  logic             w_gnt_id;
  logic [WIDTH-1:0] w_alu_z;
  logic             w_alu_err;

  // Pointer only matters under contention; a lone requester always wins.
  assign w_idle   = (r_state == ST_IDLE) && !reset;
  assign w_gnt    = w_idle && (req0_valid || req1_valid);
  assign w_gnt_id = (req0_valid && req1_valid) ? r_ptr : req1_valid;

  assign req0_ready = w_gnt && !w_gnt_id;
  assign req1_ready = w_gnt && w_gnt_id;

  yAlu #(.WIDTH(WIDTH)) u_alu (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_op  (r_op),
    .o_z   (w_alu_z),
    .o_err (w_alu_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_AND;
      r_id    <= 1'b0;
      r_z     <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt) begin
            r_a     <= w_gnt_id ? req1_a  : req0_a;
            r_b     <= w_gnt_id ? req1_b  : req0_b;
            r_op    <= w_gnt_id ? req1_op : req0_op;
            r_id    <= w_gnt_id;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_z     <= w_alu_z;
          r_err   <= w_alu_err;
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_ptr   <= !r_id;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_z     = r_z;
  assign rsp_id    = r_id;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: reset, latency, contention,
// fairness, back-pressure, SLT/illegal ops and reset mid-operation.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_z;
  logic        rsp_id, rsp_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_z      (rsp_z),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a response, checks it, then spends one cycle for the handshake.
  task automatic expect_rsp(input string tag, input logic [31:0] z, input logic id, input logic err);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    #1;
    if (rsp_valid !== 1'b1) begin
      check({tag, "_timeout"}, {31'd0, rsp_valid}, 32'd1);
    end else begin
      $display("txn %s: id=%0d z=%h err=%0b", tag, rsp_id, rsp_z, rsp_err);
      check({tag, "_z"}, rsp_z, z);
      check({tag, "_id"}, {31'd0, rsp_id}, {31'd0, id});
      check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, err});
    end
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = 3'b000;
    req1_a = '0; req1_b = '0; req1_op = 3'b000;

    // Reset state, readies suppressed while reset high
    cyc(); cyc();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2;
    check("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check("rst_ready1", {31'd0, req1_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_z", rsp_z, 32'd0);
    check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc(); reset = 1'b0;

    // Single request: 7 + 5, exact two-cycle latency
    req0_a = 32'd7; req0_b = 32'd5; req0_op = 3'b010; req0_valid = 1'b1;
    #2;
    check("single_ready0", {31'd0, req0_ready}, 32'd1);
    check("single_ready1", {31'd0, req1_ready}, 32'd0);
    check("single_idle_valid", {31'd0, rsp_valid}, 32'd0);
    cyc(); req0_valid = 1'b0; #2;
    check("single_exec_ready0", {31'd0, req0_ready}, 32'd0);
    check("single_exec_valid", {31'd0, rsp_valid}, 32'd0);
    cyc(); #2;
    $display("txn single: id=%0d z=%h err=%0b", rsp_id, rsp_z, rsp_err);
    check("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("single_z", rsp_z, 32'd12);
    check("single_id", {31'd0, rsp_id}, 32'd0);
    check("single_err", {31'd0, rsp_err}, 32'd0);
    rsp_ready = 1'b1;
    cyc(); #2;
    check("single_after_ack_valid", {31'd0, rsp_valid}, 32'd0);

    // Contention after reset: req0 first (5-7), then req1 (0xF0 & 0x3C)
    reset = 1'b1; cyc(); reset = 1'b0;
    req0_a = 32'd5;    req0_b = 32'd7;    req0_op = 3'b110; req0_valid = 1'b1;
    req1_a = 32'hF0;   req1_b = 32'h3C;   req1_op = 3'b000; req1_valid = 1'b1;
    #2;
    check("cont_ready0", {31'd0, req0_ready}, 32'd1);
    check("cont_ready1", {31'd0, req1_ready}, 32'd0);
    cyc(); req0_valid = 1'b0;
    expect_rsp("cont0", 32'hFFFF_FFFE, 1'b0, 1'b0);
    #2;
    check("cont_second_ready1", {31'd0, req1_ready}, 32'd1);
    cyc(); req1_valid = 1'b0;
    expect_rsp("cont1", 32'h30, 1'b1, 1'b0);

    // Fairness: both valid continuously, ids alternate from 0
    reset = 1'b1; cyc(); reset = 1'b0;
    req0_a = 32'd1;  req0_b = 32'd2;  req0_op = 3'b010; req0_valid = 1'b1;
    req1_a = 32'h0F; req1_b = 32'hF0; req1_op = 3'b001; req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      expect_rsp($sformatf("fair%0d", i), (i % 2 == 1) ? 32'hFF : 32'd3, 1'(i % 2), 1'b0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Back-pressure: hold RESP for 5 cycles with both requesters waiting
    reset = 1'b1; cyc(); reset = 1'b0;
    rsp_ready = 1'b0;
    req0_a = 32'hF0; req0_b = 32'h3C; req0_op = 3'b000; req0_valid = 1'b1;
    req1_a = 32'h0F; req1_b = 32'hF0; req1_op = 3'b001; req1_valid = 1'b1;
    cyc(); cyc();
    for (int i = 0; i < 5; i++) begin
      #2;
      check($sformatf("bp%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("bp%0d_z", i), rsp_z, 32'h30);
      check($sformatf("bp%0d_id", i), {31'd0, rsp_id}, 32'd0);
      check($sformatf("bp%0d_err", i), {31'd0, rsp_err}, 32'd0);
      check($sformatf("bp%0d_ready0", i), {31'd0, req0_ready}, 32'd0);
      check($sformatf("bp%0d_ready1", i), {31'd0, req1_ready}, 32'd0);
      cyc();
    end
    $display("txn bp: id=%0d z=%h err=%0b", rsp_id, rsp_z, rsp_err);
    rsp_ready = 1'b1;
    cyc(); #2;
    check("bp_next_ready1", {31'd0, req1_ready}, 32'd1);
    check("bp_next_ready0", {31'd0, req0_ready}, 32'd0);
    cyc(); req0_valid = 1'b0; req1_valid = 1'b0;
    expect_rsp("bp_next", 32'hFF, 1'b1, 1'b0);

    // SLT signed compare and illegal op codes
    req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_op = 3'b111; req0_valid = 1'b1;
    cyc(); req0_valid = 1'b0;
    expect_rsp("slt_neg", 32'd1, 1'b0, 1'b0);
    req0_a = 32'd1; req0_b = 32'hFFFF_FFFF; req0_op = 3'b111; req0_valid = 1'b1;
    cyc(); req0_valid = 1'b0;
    expect_rsp("slt_pos", 32'd0, 1'b0, 1'b0);
    req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_op = 3'b100; req0_valid = 1'b1;
    cyc(); req0_valid = 1'b0;
    expect_rsp("illegal100", 32'd0, 1'b0, 1'b1);
    req0_a = 32'h1234; req0_b = 32'h5678; req0_op = 3'b011; req0_valid = 1'b1;
    cyc(); req0_valid = 1'b0;
    expect_rsp("illegal011", 32'd0, 1'b0, 1'b1);

    // Reset in EXEC aborts; pending requests regranted to requester 0
    reset = 1'b1; cyc(); reset = 1'b0;
    req1_a = 32'h0F; req1_b = 32'hF0; req1_op = 3'b001; req1_valid = 1'b1;
    cyc();
    reset = 1'b1;
    req0_a = 32'd7; req0_b = 32'd5; req0_op = 3'b010; req0_valid = 1'b1;
    #2;
    check("rexec_ready0", {31'd0, req0_ready}, 32'd0);
    check("rexec_ready1", {31'd0, req1_ready}, 32'd0);
    cyc(); reset = 1'b0; #2;
    check("rexec_valid", {31'd0, rsp_valid}, 32'd0);
    check("rexec_regrant0", {31'd0, req0_ready}, 32'd1);
    check("rexec_regrant1", {31'd0, req1_ready}, 32'd0);
    cyc(); req0_valid = 1'b0; req1_valid = 1'b0;
    expect_rsp("rexec_regrant", 32'd12, 1'b0, 1'b0);

    // Reset in RESP clears response fields and no response appears
    rsp_ready = 1'b0;
    req1_a = 32'h0F; req1_b = 32'hF0; req1_op = 3'b001; req1_valid = 1'b1;
    cyc(); req1_valid = 1'b0;
    cyc(); #2;
    check("rresp_before_z", rsp_z, 32'hFF);
    check("rresp_before_id", {31'd0, rsp_id}, 32'd1);
    reset = 1'b1;
    cyc(); reset = 1'b0; #2;
    check("rresp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rresp_z", rsp_z, 32'd0);
    check("rresp_id", {31'd0, rsp_id}, 32'd0);
    check("rresp_err", {31'd0, rsp_err}, 32'd0);
    cyc(); cyc(); #2;
    check("rresp_no_rsp", {31'd0, rsp_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req0_valid, req1_valid  input  1 each  requester n presents an operation.
REQ-005 Port: req0_ready, req1_ready  output  1 each  requester n's operation accepted this cycle.
REQ-006 Port: req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
REQ-007 Port: req0_op, req1_op  input  3 each  op code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-008 Port: rsp_valid  output  1  result available.
REQ-009 Port: rsp_ready  input  1  consumer takes the result.
REQ-010 Port: rsp_z  output  WIDTH  result.
REQ-011 Port: rsp_id  output  1  index of the requester that owns the result.
REQ-012 Port: rsp_err  output  1  op code was illegal (011, 100, 101).

Function
REQ-013 The FSM SHALL have three states: IDLE, EXEC, RESP.
REQ-014 In IDLE with at least one reqN_valid, the block SHALL grant exactly one requester; reqN_ready SHALL be high only for the granted requester, in that same cycle (combinational from valid and state).
REQ-015 Arbitration SHALL be round-robin: a 1-bit priority pointer favours the requester not served last; a lone valid requester SHALL always win.
REQ-016 On grant, the block SHALL latch a, b, op and id into internal registers and move to EXEC.
REQ-017 In EXEC, the latched operands SHALL drive the shared ALU; the result SHALL be registered into rsp_z/rsp_err and the state SHALL move to RESP (one cycle).
REQ-018 ALU results: AND/OR bitwise; ADD/SUB modulo 2^32 with carry discarded; SLT SHALL return 1 when a < b as signed two's complement, else 0, in bit 0 with the upper bits at 0.
REQ-019 An illegal op SHALL yield rsp_z = 0 and rsp_err = 1; a legal op SHALL yield rsp_err = 0.
REQ-020 In RESP, rsp_valid SHALL be 1, and rsp_z, rsp_id and rsp_err SHALL hold stable until rsp_ready is sampled high.
REQ-021 When rsp_valid & rsp_ready, the block SHALL return to IDLE and set the pointer to favour !rsp_id.
REQ-022 Latency: a grant at edge N SHALL produce rsp_valid at edge N+2; the minimum issue interval is 3 cycles.
REQ-023 Both ready outputs SHALL be 0 in EXEC and RESP; a requester that is not granted SHALL keep its valid signal asserted and its operands stable (sender obligation).
REQ-024 rsp_valid SHALL be 0 in IDLE and EXEC.

Reset
REQ-025 With reset high at a clock edge, the state SHALL become IDLE, the pointer SHALL favour requester 0, and rsp_valid, rsp_z, rsp_id and rsp_err SHALL all be 0.
REQ-026 Reset asserted mid-operation (in EXEC or RESP) SHALL abort the operation with no response.
REQ-027 While reset is high, req0_ready and req1_ready SHALL be 0.

Structure
REQ-028 The op-code constants and the FSM state encodings SHALL reside in the shared ALU package/include, alongside the existing ALU op definitions.
REQ-029 The datapath SHALL instantiate exactly one ALU sub-module, yAlu, fed only from the latched operand registers.
REQ-030 The arbitration, FSM and response registers SHALL be local to alu_arbiter.

Verification
REQ-031 Single request: req0 valid with a=7, b=5, op=010 -> req0_ready same cycle, rsp_valid 2 cycles later, rsp_z=12, rsp_id=0, rsp_err=0.
REQ-032 Contention: both valid after reset, ops 110 (a=5, b=7) and 000 (a=0xF0, b=0x3C) -> req0 served first with z=0xFFFFFFFE; then req1 with z=0x30, rsp_id=1.
REQ-033 Fairness: both valid continuously over 6 transactions -> rsp_id alternates 0, 1, 0, 1, 0, 1.
REQ-034 Back-pressure: rsp_ready low for 5 cycles in RESP -> rsp_valid and all response fields stable, both ready outputs 0, no new grant.
REQ-035 SLT/illegal: a=0xFFFFFFFF, b=1, op=111 -> z=1; op=100 -> z=0, rsp_err=1.
REQ-036 Reset in EXEC -> next cycle IDLE, rsp_valid 0, a pending request granted afresh to requester 0.
